// File: rtl/menu_select_fsm_pkg.sv
// Shared encodings for the game menu controller and the VGA datapath mux.
// Screen states double as the VGA mux select, so the two must stay aligned.
package menu_select_fsm_pkg;

    typedef enum logic [1:0] {
        ST_SPLASH = 2'd0,
        ST_MENU   = 2'd1,
        ST_PLAY   = 2'd2,
        ST_PAUSE  = 2'd3
    } state_e;

    localparam logic [1:0] VGA_MUX_SPLASH = 2'd0;
    localparam logic [1:0] VGA_MUX_MENU   = 2'd1;
    localparam logic [1:0] VGA_MUX_PLAY   = 2'd2;
    localparam logic [1:0] VGA_MUX_PAUSE  = 2'd3;

    // 10 ms debounce and 250 ms auto-repeat at 100 MHz
    localparam int DEFAULT_DEBOUNCE_CYC = 1000000;
    localparam int DEFAULT_REPEAT_CYC   = 25000000;

    // Width of a counter that must hold 0..n-1 (never narrower than one bit)
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/menu_select_fsm_btn_conditioner.sv
// One push button: 2-flop synchroniser, counter debounce, rising-edge pulse.
// level follows the synchronised input only after it has disagreed for
// DEBOUNCE_CYC consecutive cycles; pulse is one cycle wide, one cycle after
// level rises.
module btn_conditioner
    import menu_select_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             db_q, db_d;
    logic             db_prev_q, db_prev_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next state: any agreement between sync and level restarts the count
    always_comb begin
        meta_d    = raw;
        sync_d    = meta_q;
        db_d      = db_q;
        cnt_d     = '0;
        if (sync_q != db_q) begin
            if (cnt_q == CNT_LAST) db_d = sync_q;
            else                   cnt_d = cnt_q + CNT_W'(1);
        end
        db_prev_d = db_q;
        pulse_d   = db_q & ~db_prev_q;
    end

    // Register everything; reset discards any press in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level = db_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/menu_select_fsm.sv
// Game menu controller: conditions four buttons, runs the splash/menu/play/
// pause screen FSM and drives the VGA screen select and selected game index.
// Optional build macro MENU_AUTOREPEAT_EN adds hold-to-repeat on up/down in
// the menu; without it each press moves the cursor exactly once.
module menu_select_fsm
    import menu_select_fsm_pkg::*;
#(
    parameter int NUM_CHOICES  = 4,
    parameter int CHOICE_W     = 3,
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int REPEAT_CYC   = DEFAULT_REPEAT_CYC,
    parameter int WRAP         = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                game_exit,
    output logic [CHOICE_W-1:0] choice,
    output logic [1:0]          vga_mux,
    output logic                game_start,
    output logic [1:0]          fsm_state
);

    // Cursor math runs one bit wider so the end compare cannot alias
    localparam int            XW   = CHOICE_W + 1;
    localparam logic [XW-1:0] LAST = XW'(NUM_CHOICES - 1);

    logic p_up, p_dn, p_left, p_right;
    logic step_up, step_dn;

    state_e              state_q, state_d;
    logic [CHOICE_W-1:0] choice_q, choice_d;
    logic                game_start_q, game_start_d;
    logic [XW-1:0]       cur, nxt;

`ifdef MENU_AUTOREPEAT_EN
    logic l_up, l_dn;
`endif

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_up (
        .clk(sys_clk), .rst_n(sys_rst_n), .raw(btn_up), .pulse(p_up),
`ifdef MENU_AUTOREPEAT_EN
        .level(l_up)
`else
        .level()
`endif
    );

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_down (
        .clk(sys_clk), .rst_n(sys_rst_n), .raw(btn_down), .pulse(p_dn),
`ifdef MENU_AUTOREPEAT_EN
        .level(l_dn)
`else
        .level()
`endif
    );

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_left (
        .clk(sys_clk), .rst_n(sys_rst_n), .raw(btn_left), .pulse(p_left), .level()
    );

    btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn_right (
        .clk(sys_clk), .rst_n(sys_rst_n), .raw(btn_right), .pulse(p_right), .level()
    );

`ifdef MENU_AUTOREPEAT_EN
    localparam int               RPT_W    = cnt_width(REPEAT_CYC);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             held, rpt_fire;

    // Only a lone up or down held in the menu repeats
    assign held     = (state_q == ST_MENU) && (l_up ^ l_dn);
    assign rpt_fire = held && (rpt_cnt_q == RPT_LAST);
    assign step_up  = p_up | (rpt_fire & l_up);
    assign step_dn  = p_dn | (rpt_fire & l_dn);

    // Repeat timer restarts on each press, each repeat, release or screen change
    always_comb begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        if (!held || rpt_fire || p_up || p_dn || (state_d != state_q))
            rpt_cnt_d = '0;
    end

    // Repeat timer register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) rpt_cnt_q <= '0;
        else            rpt_cnt_q <= rpt_cnt_d;
    end
`else
    assign step_up = p_up;
    assign step_dn = p_dn;
`endif

    // Cursor candidate: wrap or saturate at the ends; up+down together cancels
    always_comb begin
        cur = {1'b0, choice_q};
        nxt = cur;
        if (step_dn && !step_up) begin
            if (cur >= LAST) nxt = (WRAP != 0) ? '0 : LAST;
            else             nxt = cur + XW'(1);
        end else if (step_up && !step_dn) begin
            if (cur == '0) nxt = (WRAP != 0) ? LAST : '0;
            else           nxt = cur - XW'(1);
        end
    end

    // Screen FSM next state; game_exit outranks buttons while in a game
    always_comb begin
        state_d      = state_q;
        choice_d     = choice_q;
        game_start_d = 1'b0;
        case (state_q)
            ST_SPLASH: if (p_right) state_d = ST_MENU;
            ST_MENU: begin
                if (p_right) begin
                    state_d      = ST_PLAY;
                    game_start_d = 1'b1;
                end else if (p_left) begin
                    state_d = ST_SPLASH;
                end else begin
                    choice_d = nxt[CHOICE_W-1:0];
                end
            end
            ST_PLAY: begin
                if (game_exit)   state_d = ST_MENU;
                else if (p_left) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (game_exit || p_left) state_d = ST_MENU;
                else if (p_right)        state_d = ST_PLAY;
            end
            default: state_d = ST_SPLASH;
        endcase
    end

    // FSM and registered outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= ST_SPLASH;
            choice_q     <= '0;
            game_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            choice_q     <= choice_d;
            game_start_q <= game_start_d;
        end
    end

    assign choice     = choice_q;
    assign vga_mux    = state_q;
    assign fsm_state  = state_q;
    assign game_start = game_start_q;

endmodule

// File: doc/menu_select_fsm.md
Name: menu_select_fsm

Overview:
Parametrised successor to the game-menu controller in the top-level game/VGA design.
- Takes raw push-button inputs, synchronises and debounces them, and turns them into edge pulses.
- Runs the screen-level state machine (splash / menu / play / pause).
- Drives the VGA screen-select mux and the selected-game index into the datapath.
- Generalised over number of menu entries, cursor wrap mode and debounce timing; adds pause and optional hold-to-repeat.

Parameters:
NUM_CHOICES, 4, number of selectable menu entries (2..2**CHOICE_W)
CHOICE_W, 3, width of choice output
DEBOUNCE_CYC, 1000000, cycles a synchronised input must stay stable to be accepted (10 ms at 100 MHz)
REPEAT_CYC, 25000000, hold time between auto-repeat steps (only used with MENU_AUTOREPEAT_EN)
WRAP, 1, 1 = cursor wraps at the ends, 0 = cursor saturates

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset: synchronous, active-low
btn_up  in  1  raw asynchronous button, active-high
btn_down  in  1  raw asynchronous button, active-high
btn_left  in  1  raw asynchronous button, active-high (back / pause)
btn_right  in  1  raw asynchronous button, active-high (confirm)
game_exit  in  1  one-cycle pulse from the game datapath: game finished or exit pressed
choice  out  CHOICE_W  current menu cursor / selected game
vga_mux  out  2  screen select: 0 splash, 1 menu, 2 play, 3 pause
game_start  out  1  one-cycle pulse on game launch
fsm_state  out  2  debug copy of the state encoding

Behaviour:
Reset (sys_rst_n=0 at a sys_clk edge):
- state=SPLASH, choice=0, vga_mux=0, game_start=0.
- All synchronisers, debounce counters and repeat counters are cleared.
- Reset mid-debounce or mid-game discards all pending presses.

Button conditioning, per button:
- 2-flop synchroniser.
- Debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the counter.
- Press pulse = rising edge of the debounced level, exactly 1 cycle wide.
- Latency from a clean raw edge to the pulse: 2 + DEBOUNCE_CYC + 1 cycles.

FSM (all outputs registered; they update on the edge after the pulse cycle):
- SPLASH:
  - right -> MENU.
  - Other buttons ignored.
- MENU:
  - up -> choice-1; down -> choice+1.
  - At the ends: with WRAP=1, 0 -> NUM_CHOICES-1 and vice versa; with WRAP=0, choice holds at the end.
  - up and down pulsed in the same cycle -> no move.
  - right -> PLAY, with game_start=1 for exactly that transition cycle.
  - left -> SPLASH.
- PLAY:
  - choice frozen.
  - left -> PAUSE.
  - game_exit -> MENU; game_exit has priority over any same-cycle button pulse.
- PAUSE:
  - right -> PLAY, with no game_start pulse.
  - left -> MENU.
  - game_exit -> MENU.
- Other states: game_exit is ignored outside PLAY/PAUSE.
- Encoding: vga_mux equals the state encoding (SPLASH=0, MENU=1, PLAY=2, PAUSE=3).
- Arithmetic: choice arithmetic is done CHOICE_W+1 wide before the compare, so choice never leaves 0..NUM_CHOICES-1.

Optional Feature:
MENU_AUTOREPEAT_EN
- Defined:
  - In MENU, a debounced up/down level held continuously generates an extra step pulse every REPEAT_CYC cycles after the initial press pulse.
  - The repeat counter clears on release or on any state change.
- Undefined:
  - Exactly one step per press.
  - No repeat counter is synthesised.

Decomposition:
- Shared package: state encodings (ST_SPLASH..ST_PAUSE), VGA_MUX_* constants and the default debounce/repeat cycle constants, shared with the datapath mux.
- One sub-module, btn_conditioner (synchroniser + debounce + edge pulse, parameter DEBOUNCE_CYC), instantiated four times.
- FSM, cursor logic and auto-repeat live in the top of the block.

Test Plan:
All scenarios use sim parameters DEBOUNCE_CYC=4, REPEAT_CYC=10, NUM_CHOICES=3.
- Reset then idle 20 cycles -> vga_mux=0, choice=0, game_start=0 throughout.
- btn_right held 8 cycles -> vga_mux=1 on cycle 8 after the raw edge (2 + 4 + 1 + 1).
- btn_right with 3-cycle glitches every 3 cycles -> no state change.
- In MENU with WRAP=1, btn_up pressed once -> choice=2; then btn_down pressed twice -> choice=1.
- Repeat the previous scenario with WRAP=0 -> up from 0 holds choice=0; down x3 gives choice=2.
- In MENU, btn_right -> game_start high exactly 1 cycle, vga_mux=2; then btn_left -> vga_mux=3; then game_exit -> vga_mux=1 with choice unchanged.
- game_exit and btn_left pulse in the same cycle in PLAY -> vga_mux=1, not 3.
- With MENU_AUTOREPEAT_EN, btn_down held 40 cycles in MENU -> initial step plus one step every 10 cycles, wrapping 0->1->2->0.
